// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_bridge
// Description : SPI peripheral (mode 0, MSB first) acting as a register-bus
//               initiator. Frame: command byte {RW, INC, 6'bx}, ADDR_W
//               address bits, then DATA_W-bit words (writes) or 8 dummy bits
//               followed by DATA_W-bit words (reads). Bursts repeat words,
//               with optional address auto-increment. Strobes that are not
//               acknowledged within ACK_TO clocks are dropped and the sticky
//               err flag is set.
// Ports       : clk, rst            - system clock, sync active-high reset
//               sclk, cs, mosi      - SPI inputs (asynchronous to clk)
//               miso, miso_oe       - SPI output and its enable
//               reg_addr/wdat/wr/rd - register bus request
//               reg_rdat, reg_ack   - register bus response
//               err, busy           - sticky timeout flag, activity flag
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int ACK_TO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdat,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdat,
    input  logic              reg_ack,
    output logic              err,
    output logic              busy
);

    localparam int c_MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_CNT_W = $clog2(c_MAXW + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_BYTE = c_CNT_W'(8);
    localparam logic [c_CNT_W-1:0] c_CNT_ADDR = c_CNT_W'(ADDR_W);
    localparam logic [c_CNT_W-1:0] c_CNT_DATA = c_CNT_W'(DATA_W);
    localparam logic [7:0]         c_TO_LAST  = 8'(ACK_TO - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_CMD   = 3'd1;
    localparam logic [2:0] c_S_ADDR  = 3'd2;
    localparam logic [2:0] c_S_DUMMY = 3'd3;
    localparam logic [2:0] c_S_WDATA = 3'd4;
    localparam logic [2:0] c_S_RDATA = 3'd5;

    logic [2:0]         r_sclk_s;
    logic [2:0]         r_cs_s;
    logic [1:0]         r_mosi_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_MAXW-2:0]  r_shin;
    logic [DATA_W-2:0]  r_out;
    logic [DATA_W-1:0]  r_rbuf;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_rw;
    logic               r_inc;
    logic [7:0]         r_to_cnt;

    logic               w_in_frame;
    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_rise;
    logic               w_fall;
    logic               w_strobe;
    logic               w_exit;
    logic [c_MAXW-1:0]  w_shin;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic [ADDR_W-1:0]  w_addr_inc;
    logic [ADDR_W-1:0]  w_addr_nx;

    // Two synchroniser flops per input; the third sclk/cs flop is the edge
    // detector. mosi stage 1 lines up with sclk stage 1 at the detected edge.
    // cs resets to the "low" level so a cs already held low after reset
    // cannot fake a falling edge; a fresh high-to-low transition is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s <= '0;
            r_cs_s   <= '0;
            r_mosi_s <= '0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], sclk};
            r_cs_s   <= {r_cs_s[1:0], cs};
            r_mosi_s <= {r_mosi_s[0], mosi};
        end
    end

    assign w_cs_fall  = r_cs_s[2] & ~r_cs_s[1];
    assign w_cs_rise  = ~r_cs_s[2] & r_cs_s[1];
    // Gate on the older cs sample so an sclk edge coinciding with the cs rise
    // is still taken (completes a word finished right at the frame end).
    assign w_in_frame = ~r_cs_s[2] & (r_state != c_S_IDLE);
    assign w_rise     = w_in_frame & r_sclk_s[1] & ~r_sclk_s[2];
    assign w_fall     = w_in_frame & ~r_sclk_s[1] & r_sclk_s[2];
    assign w_shin     = {r_shin, r_mosi_s[1]};
    assign w_cnt_nx   = r_cnt + 1'b1;
    assign w_strobe   = reg_wr | reg_rd;
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_addr_nx  = r_inc ? w_addr_inc : r_addr;
    // Leave the frame only once cs is high and no strobe is in flight or
    // about to be launched this cycle.
    assign w_exit     = r_cs_s[1] & ~w_strobe & ~w_rise & ~w_fall;
    assign busy       = (r_state != c_S_IDLE) | w_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= '0;
            r_shin   <= '0;
            r_out    <= '0;
            r_rbuf   <= '0;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_inc    <= 1'b0;
            r_to_cnt <= '0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            reg_addr <= '0;
            reg_wdat <= '0;
            reg_wr   <= 1'b0;
            reg_rd   <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Bus strobe completion. Ack wins over a coincident timeout.
            if (w_strobe) begin
                if (reg_ack) begin
                    reg_wr <= 1'b0;
                    reg_rd <= 1'b0;
                    if (reg_rd) r_rbuf <= reg_rdat;
                    if (reg_wr && r_inc) r_addr <= w_addr_inc;
                end else if (r_to_cnt == c_TO_LAST) begin
                    reg_wr <= 1'b0;
                    reg_rd <= 1'b0;
                    err    <= 1'b1;
                    if (reg_rd) r_rbuf <= '0;
                    if (reg_wr && r_inc) r_addr <= w_addr_inc;
                end else begin
                    r_to_cnt <= r_to_cnt + 8'd1;
                end
            end

            // Frame start / end
            if (r_state == c_S_IDLE) begin
                if (w_cs_fall) begin
                    r_state <= c_S_CMD;
                    r_cnt   <= '0;
                    miso    <= 1'b0;
                    miso_oe <= 1'b1;
                end
            end else if (w_exit) begin
                r_state <= c_S_IDLE;
                miso    <= 1'b0;
            end
            if (w_cs_rise) miso_oe <= 1'b0;

            // Rising sclk: sample mosi, advance the frame
            if (w_rise) begin
                r_shin <= w_shin[c_MAXW-2:0];
                r_cnt  <= w_cnt_nx;
                case (r_state)
                    c_S_CMD: begin
                        if (w_cnt_nx == c_CNT_BYTE) begin
                            r_rw    <= w_shin[7];
                            r_inc   <= w_shin[6];
                            r_cnt   <= '0;
                            r_state <= c_S_ADDR;
                        end
                    end
                    c_S_ADDR: begin
                        if (w_cnt_nx == c_CNT_ADDR) begin
                            r_addr <= w_shin[ADDR_W-1:0];
                            r_cnt  <= '0;
                            if (r_rw) begin
                                r_state <= c_S_WDATA;
                            end else begin
                                // Prefetch the first read word during the dummy byte
                                r_state  <= c_S_DUMMY;
                                reg_addr <= w_shin[ADDR_W-1:0];
                                reg_rd   <= 1'b1;
                                r_to_cnt <= '0;
                            end
                        end
                    end
                    c_S_DUMMY: begin
                        if (w_cnt_nx == c_CNT_BYTE) begin
                            r_cnt   <= '0;
                            r_state <= c_S_RDATA;
                        end
                    end
                    c_S_WDATA: begin
                        if (w_cnt_nx == c_CNT_DATA) begin
                            r_cnt    <= '0;
                            reg_wdat <= w_shin[DATA_W-1:0];
                            reg_addr <= r_addr;
                            reg_wr   <= 1'b1;
                            r_to_cnt <= '0;
                        end
                    end
                    c_S_RDATA: begin
                        if (w_cnt_nx == c_CNT_DATA) r_cnt <= '0;
                    end
                    default: r_state <= c_S_IDLE;
                endcase
            end

            // Falling sclk in RDATA: load a new word at a word boundary
            // (and launch the next read), otherwise shift out the next bit.
            if (w_fall && (r_state == c_S_RDATA)) begin
                if (r_cnt == '0) begin
                    miso     <= r_rbuf[DATA_W-1];
                    r_out    <= r_rbuf[DATA_W-2:0];
                    r_addr   <= w_addr_nx;
                    reg_addr <= w_addr_nx;
                    reg_rd   <= 1'b1;
                    r_to_cnt <= '0;
                end else begin
                    miso  <= r_out[DATA_W-2];
                    r_out <= {r_out[DATA_W-3:0], 1'b0};
                end
            end
        end
    end

endmodule
`default_nettype wire
